// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default bit period and idle line level shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: fifo read port plus serial line and busy flag of the FIFO-draining UART transmitter.
interface fifo_uart_tx_if #(
    parameter int DATA_BITS = 9
);

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_rd;
    logic                 tx;
    logic                 busy;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd,
        output tx,
        output busy
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd,
        input  tx,
        input  busy
    );

endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick: bit-period counter with synchronous clear; tick is high on the last clock of each period.
module baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(CLKS_PER_BIT - 1);

    // Counts 0..CLKS_PER_BIT-1 and reloads on the tick; held at zero while cleared.
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops items from a fifo and sends each LSB first as a start/data/stop frame; define UART_TX_PARITY_EN to add an even parity bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 9,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input logic            clk,
    input logic            rst,
    fifo_uart_tx_if.master bus
);

    localparam int BW = $clog2(DATA_BITS + 1);

    state_t               state, state_next;
    logic                 line, line_next;
    logic                 strobe, strobe_next;
    logic                 active, active_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [BW-1:0]        bit_cnt, bit_next;
    logic                 tick, clr;
`ifdef UART_TX_PARITY_EN
    logic                 parity, parity_next;
`endif

    assign clr         = state inside {IDLE, FETCH, WAIT};
    assign bus.tx      = line;
    assign bus.fifo_rd = strobe;
    assign bus.busy    = active;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // State, shift register and registered outputs; reset drops any captured item.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            line    <= LINE_IDLE;
            strobe  <= 1'b0;
            active  <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            line    <= line_next;
            strobe  <= strobe_next;
            active  <= active_next;
            shift   <= shift_next;
            bit_cnt <= bit_next;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end

    // Next state and next output values; outputs are registered from these so they align with the state.
    always_comb begin
        state_next  = state;
        line_next   = line;
        strobe_next = 1'b0;
        active_next = active;
        shift_next  = shift;
        bit_next    = bit_cnt;
`ifdef UART_TX_PARITY_EN
        parity_next = parity;
`endif
        case (state)
            IDLE: begin
                line_next = LINE_IDLE;
                if (!bus.fifo_empty) begin
                    state_next  = FETCH;
                    strobe_next = 1'b1;
                    active_next = 1'b1;
                end
            end
            FETCH: state_next = WAIT;
            WAIT: begin
                state_next = START;
                shift_next = bus.fifo_dout;
                line_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_next = ^bus.fifo_dout;
`endif
            end
            START: if (tick) begin
                state_next = DATA;
                bit_next   = '0;
                line_next  = shift[0];
            end
            DATA: if (tick) begin
                if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
                    line_next  = parity;
`else
                    state_next = STOP;
                    line_next  = LINE_IDLE;
`endif
                end else begin
                    bit_next   = bit_cnt + 1'b1;
                    shift_next = shift >> 1;
                    line_next  = shift[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_next = STOP;
                line_next  = LINE_IDLE;
            end
`endif
            STOP: if (tick) begin
                if (!bus.fifo_empty) begin
                    state_next  = FETCH;
                    strobe_next = 1'b1;
                end else begin
                    state_next  = IDLE;
                    active_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx driven from a 36-deep fifo model; define UART_TX_PARITY_EN to cover the parity build.
module tb_fifo_uart_tx;

    localparam int C = 16;
    localparam int DEPTH = 36;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 12;
`else
    localparam int NB = 11;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr = 1'b0;
    logic [8:0] din = '0;
    logic [8:0] mem [DEPTH];
    int wp = 0, rp = 0, cnt = 0;
    int checks = 0, errors = 0;
    int pops = 0, rd_bad = 0, busy_cycles = 0;

    fifo_uart_tx_if #(.DATA_BITS(9)) bus ();

    fifo_uart_tx #(.DATA_BITS(9), .CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty = (cnt == 0);

    always @(posedge clk) begin
        if (wr && cnt < DEPTH) begin
            mem[wp] <= din;
            wp <= (wp + 1) % DEPTH;
        end
        if (bus.fifo_rd && cnt > 0) begin
            bus.fifo_dout <= mem[rp];
            rp <= (rp + 1) % DEPTH;
        end
        cnt <= cnt + ((wr && cnt < DEPTH) ? 1 : 0) - ((bus.fifo_rd && cnt > 0) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (bus.fifo_rd === 1'b1) pops++;
        if (bus.fifo_rd === 1'b1 && bus.fifo_empty) rd_bad++;
        if (bus.busy === 1'b1) busy_cycles++;
    end

    function automatic logic [NB-1:0] frame_of(input logic [8:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic push(input logic [8:0] d);
        wr = 1'b1;
        din = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_start(input int lim, output int n);
        n = 0;
        while (bus.tx !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic sample_frame(output logic [NB-1:0] b);
        repeat (C / 2) @(negedge clk);
        b[0] = bus.tx;
        for (int k = 1; k < NB; k++) begin
            repeat (C) @(negedge clk);
            b[k] = bus.tx;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 4 * NB * C) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", bus.tx); end
        checks++;
        if (bus.fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b required 0", bus.fifo_rd); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        rst = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.fifo_rd !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_quiet: %0d bad cycles, required 0", bad); end
    endtask

    task automatic test_single();
        int lat, p0, b0;
        logic [NB-1:0] got;
        p0 = pops;
        b0 = busy_cycles;
        push(9'h0A5);
        wait_start(100, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL single_latency: start after %0d edges, required 3", lat); end
        sample_frame(got);
        checks++;
        if (got !== frame_of(9'h0A5)) begin errors++; $display("FAIL single_frame: got %b required %b", got, frame_of(9'h0A5)); end
        wait_idle();
        checks++;
        if (pops - p0 != 1) begin errors++; $display("FAIL single_pops: got %0d required 1", pops - p0); end
        checks++;
        if (busy_cycles - b0 != NB * C + 2) begin
            errors++;
            $display("FAIL single_busy: got %0d cycles required %0d", busy_cycles - b0, NB * C + 2);
        end
    endtask

    task automatic test_back_to_back();
        int n, p0;
        logic [NB-1:0] got;
        logic [8:0] item;
        rst = 1'b1;
        for (int i = 0; i < 40; i++) push(9'h0A5 ^ 9'(i));
        p0 = pops;
        rst = 1'b0;
        for (int f = 0; f < DEPTH; f++) begin
            wait_start(4 * C, n);
            checks++;
            if (bus.tx !== 1'b0) begin errors++; $display("FAIL b2b_start%0d: tx=%b required 0", f, bus.tx); end
            if (f > 0) begin
                checks++;
                if (n != C / 2 + 2) begin errors++; $display("FAIL b2b_gap%0d: got %0d cycles required %0d", f, n, C / 2 + 2); end
            end
            item = 9'h0A5 ^ 9'(f);
            sample_frame(got);
            checks++;
            if (got !== frame_of(item)) begin errors++; $display("FAIL b2b_frame%0d: got %b required %b", f, got, frame_of(item)); end
        end
        wait_start(3 * C, n);
        checks++;
        if (bus.tx !== 1'b1) begin errors++; $display("FAIL b2b_extra: tx=%b required 1", bus.tx); end
        wait_idle();
        checks++;
        if (pops - p0 != DEPTH) begin errors++; $display("FAIL b2b_pops: got %0d required %0d", pops - p0, DEPTH); end
        checks++;
        if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b required 1", bus.fifo_empty); end
    endtask

    task automatic test_reset_mid();
        int n, p0;
        logic [NB-1:0] got;
        p0 = pops;
        push(9'h1FF);
        push(9'h0A5);
        wait_start(20, n);
        repeat (C / 2 + 5 * C) @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1) begin errors++; $display("FAIL mid_bit4: got %b required 1", bus.tx); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.tx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b required 1", bus.tx); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", bus.busy); end
        wait_start(20, n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL mid_restart: start after %0d edges, required 3", n); end
        sample_frame(got);
        checks++;
        if (got !== frame_of(9'h0A5)) begin errors++; $display("FAIL mid_next_frame: got %b required %b", got, frame_of(9'h0A5)); end
        wait_idle();
        checks++;
        if (pops - p0 != 2) begin errors++; $display("FAIL mid_pops: got %0d required 2", pops - p0); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int n;
        logic [NB-1:0] got;
        push(9'h0A5);
        push(9'h0A4);
        wait_start(20, n);
        sample_frame(got);
        checks++;
        if (got[10] !== 1'b0) begin errors++; $display("FAIL parity_a5: got %b required 0", got[10]); end
        checks++;
        if (got !== 12'b1_0_010100101_0) begin errors++; $display("FAIL parity_frame_a5: got %b required %b", got, 12'b1_0_010100101_0); end
        wait_start(4 * C, n);
        checks++;
        if (n != C / 2 + 2) begin errors++; $display("FAIL parity_gap: got %0d required %0d", n, C / 2 + 2); end
        sample_frame(got);
        checks++;
        if (got[10] !== 1'b1) begin errors++; $display("FAIL parity_a4: got %b required 1", got[10]); end
        checks++;
        if (got !== 12'b1_1_010100100_0) begin errors++; $display("FAIL parity_frame_a4: got %b required %b", got, 12'b1_1_010100100_0); end
        wait_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (rd_bad != 0) begin errors++; $display("FAIL rd_while_empty: got %0d strobes required 0", rd_bad); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
